// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the convolution image host.
package conv_pkg;
    localparam int IMG_DIM      = 64;
    localparam int IMG_N        = 4096;
    localparam int DATA_W       = 20;
    localparam int ADDR_W       = 12;
    localparam int BUSY_TIMEOUT = 15;

    typedef enum logic [2:0] {
        LOAD      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        DONE      = 3'd4
    } conv_state_e;
endpackage

// File: rtl/conv_img_ram.sv
// 4096x20 image store: synchronous write, asynchronous (zero-latency) read.
module conv_img_ram
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [IMG_N];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/conv_img_host.sv
// Loads one 64x64 frame from a valid/ready pixel stream, then hands it to the
// convolution engine with a start/busy handshake and serves its pixel reads.
module conv_img_host
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              ready,
    input  logic              busy,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] idata,
    output logic              done,
    output logic              err,
    output logic [7:0]        frame_cnt,
    output conv_state_e       dbg_state
);
    // Stream handshake: a beat transfers on a rising edge where s_valid and
    // s_ready are both 1; s_ready is registered and only ever high in LOAD.
    conv_state_e       state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [3:0]        timeout;
    logic              accept;
    logic              last_addr;
    logic              frame_err;

    assign accept    = s_valid && s_ready;
    assign last_addr = (wr_ptr == ADDR_W'(IMG_N - 1));
    assign frame_err = (s_last != last_addr);
    assign dbg_state = state;

    conv_img_ram u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (s_data),
        .raddr (iaddr),
        .rdata (idata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            wr_ptr    <= '0;
            timeout   <= '0;
            ready     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            frame_cnt <= '0;
            s_ready   <= 1'b1;
        end else begin
            ready <= 1'b0;
            done  <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        // A clean first beat starts a new frame and clears the sticky flag.
                        if (frame_err)          err <= 1'b1;
                        else if (wr_ptr == '0)  err <= 1'b0;
                        if (last_addr) begin
                            state   <= START;
                            s_ready <= 1'b0;
                            ready   <= 1'b1;
                        end
                    end
                end
                START: begin
                    state   <= WAIT_BUSY;
                    timeout <= '0;
                end
                WAIT_BUSY: begin
                    if (busy) begin
                        state <= RUN;
                    end else if (timeout == 4'(BUSY_TIMEOUT)) begin
                        state <= START;
                        ready <= 1'b1;
                    end else begin
                        timeout <= timeout + 1'b1;
                    end
                end
                RUN: begin
                    if (!busy) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= LOAD;
                    s_ready <= 1'b1;
                end
                default: begin
                    state   <= LOAD;
                    s_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_img_host.sv
// Directed-sequence bench for conv_img_host with a frame-level reference model.
module tb_conv_img_host;
    import conv_pkg::*;

    logic              clk;
    logic              reset;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              ready;
    logic              busy;
    logic [ADDR_W-1:0] iaddr;
    logic [DATA_W-1:0] idata;
    logic              done;
    logic              err;
    logic [7:0]        frame_cnt;
    conv_state_e       dbg_state;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model_mem [IMG_N];
    bit                model_err;
    int                cyc;
    int                bad;
    int                gap;

    conv_img_host dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .ready     (ready),
        .busy      (busy),
        .iaddr     (iaddr),
        .idata     (idata),
        .done      (done),
        .err       (err),
        .frame_cnt (frame_cnt),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: s_valid always 1, mode 1: every other cycle, mode 2: random.
    task automatic load_frame(input int mode, input int last_at, input bit rand_data,
                              output int cycles);
        int acc = 0;
        int c = 0;
        int state_bad = 0;
        int err_bad = 0;
        bit v;
        bit l;
        logic [DATA_W-1:0] d;
        while (acc < IMG_N && c < 20000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            d = rand_data ? DATA_W'($urandom) : DATA_W'(acc);
            l = (acc == last_at);
            s_valid = v;
            s_data  = d;
            s_last  = l;
            busy    = 1'($urandom_range(0, 1));
            if (s_ready !== 1'b1 || dbg_state !== LOAD) state_bad++;
            tick();
            if (v) begin
                model_mem[acc] = d;
                if (l != (acc == IMG_N - 1)) model_err = 1'b1;
                else if (acc == 0)           model_err = 1'b0;
                acc++;
                if (acc == 1) check("err_first_beat", 32'(err), 32'(model_err));
                if (last_at != IMG_N - 1 && acc == last_at + 1)
                    check("err_after_early_last", 32'(err), 32'(1));
            end
            if (acc < IMG_N && err !== model_err) err_bad++;
            c++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        busy    = 1'b0;
        check("load_beats", 32'(acc), 32'(IMG_N));
        check("load_state_ready", 32'(state_bad), 32'(0));
        check("load_err_track", 32'(err_bad), 32'(0));
        check("post_load_s_ready", 32'(s_ready), 32'(0));
        check("post_load_ready", 32'(ready), 32'(1));
        check("post_load_err", 32'(err), 32'(model_err));
        cycles = c;
    endtask

    // Must only run while the FSM is stable (LOAD with s_valid=0, or RUN with busy=1).
    task automatic readback(input string tag);
        int n = 0;
        for (int i = 0; i < IMG_N; i++) begin
            iaddr = ADDR_W'(i);
            #0.01;
            if (idata !== model_mem[i]) n++;
        end
        check(tag, 32'(n), 32'(0));
    endtask

    task automatic wait_ready_gap(output int g);
        g = 0;
        do begin
            tick();
            g++;
        end while (ready !== 1'b1 && g < 100);
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        busy = 1'b0; iaddr = '0; model_err = 1'b0;
        #2 reset = 1'b0;
        #10;
        check("rst_state", 32'(dbg_state), 32'(LOAD));
        check("rst_s_ready", 32'(s_ready), 32'(1));
        check("rst_ready", 32'(ready), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        tick();
        reset = 1'b1;
        tick();

        // Frame A: pixel k = k, clean framing.
        load_frame(0, IMG_N - 1, 1'b0, cyc);
        check("a_state_start", 32'(dbg_state), 32'(START));
        iaddr = 12'hABC; #1;
        check("a_idata_abc", 32'(idata), 32'h00ABC);
        iaddr = 12'hFFF; #1;
        check("a_idata_fff", 32'(idata), 32'h00FFF);
        tick();
        check("a_ready_one_cycle", 32'(ready), 32'(0));
        check("a_state_wait", 32'(dbg_state), 32'(WAIT_BUSY));
        // Engine never answers: start request repeats.
        s_valid = 1'b1; s_data = '1;
        wait_ready_gap(gap);
        gap++;
        check("a_timeout_period1", 32'(gap), 32'(17));
        wait_ready_gap(gap);
        check("a_timeout_period2", 32'(gap), 32'(17));
        tick(); tick(); tick();
        busy = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (dbg_state !== RUN || ready !== 1'b0 || s_ready !== 1'b0) bad++;
        end
        check("a_run_hold", 32'(bad), 32'(0));
        busy = 1'b0; s_valid = 1'b0;
        tick();
        check("a_done_pulse", 32'(done), 32'(1));
        tick();
        check("a_done_one_cycle", 32'(done), 32'(0));
        check("a_s_ready_back", 32'(s_ready), 32'(1));
        check("a_state_load", 32'(dbg_state), 32'(LOAD));
        check("a_frame_cnt", 32'(frame_cnt), 32'(1));
        readback("a_readback");

        // Frame B: every-other-cycle valid, early s_last on beat 100.
        load_frame(1, 100, 1'b1, cyc);
        check("b_cycles", 32'(cyc), 32'(2 * IMG_N - 1));
        check("b_err_sticky", 32'(err), 32'(1));
        tick();
        busy = 1'b1;
        tick();
        check("b_state_run", 32'(dbg_state), 32'(RUN));
        busy = 1'b0;
        tick(); tick();
        check("b_frame_cnt", 32'(frame_cnt), 32'(2));
        check("b_err_held", 32'(err), 32'(1));
        readback("b_readback");

        // Frame C: random valid, clean framing; then reset during RUN.
        load_frame(2, IMG_N - 1, 1'b1, cyc);
        check("c_err_clear", 32'(err), 32'(0));
        tick();
        busy = 1'b1;
        tick(); tick();
        check("c_state_run", 32'(dbg_state), 32'(RUN));
        reset = 1'b0;
        #1;
        check("c_rst_state", 32'(dbg_state), 32'(LOAD));
        check("c_rst_ready", 32'(ready), 32'(0));
        check("c_rst_err", 32'(err), 32'(0));
        check("c_rst_frame_cnt", 32'(frame_cnt), 32'(0));
        check("c_rst_s_ready", 32'(s_ready), 32'(1));
        tick();
        reset = 1'b1;
        busy = 1'b0;
        tick();

        // Frame D: fresh load from address 0 after the abandoned frame.
        load_frame(0, IMG_N - 1, 1'b1, cyc);
        check("d_err", 32'(err), 32'(0));
        tick();
        busy = 1'b1;
        tick();
        check("d_state_run", 32'(dbg_state), 32'(RUN));
        readback("d_readback");
        busy = 1'b0;
        tick();
        check("d_done", 32'(done), 32'(1));
        tick();
        check("d_frame_cnt", 32'(frame_cnt), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
